// File: rtl/svm_stream_feeder.sv
//============================================================================
// svm_stream_feeder
//   Feeds image, support-vector, lambda and bias bursts from parameter
//   memory to the SVM core stream port, one burst per interrupt edge.
//   Revision: 1.0
//============================================================================
`default_nettype none

module svm_stream_feeder #(
  parameter int                        WIDTH     = 16,
  parameter int                        IMG_LEN   = 784,
  parameter int                        NUM_CORES = 10,
  parameter logic [NUM_CORES*10-1:0]   SV_COUNTS = {10'd683, 10'd751, 10'd432, 10'd376, 10'd513,
                                                    10'd80,  10'd632, 10'd581, 10'd267, 10'd361},
  parameter int                        ADDR_W    = 22,
  parameter int unsigned               IMG_BASE  = 0,
  parameter int unsigned               SV_BASE   = 784,
  parameter int unsigned               LT_BASE   = 3666768,
  parameter int unsigned               B_BASE    = 3671444
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              interrupt,
  output logic [WIDTH-1:0]  sdata,
  output logic              svalid,
  input  logic              sready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [WIDTH-1:0]  mem_data,
  output logic              busy,
  output logic [3:0]        core_idx,
  output logic              done,
  output logic              err
);

  localparam int                CNT_W      = $clog2(IMG_LEN + 1);
  localparam logic [CNT_W-1:0]  IMG_LEN_C  = CNT_W'(IMG_LEN);
  localparam logic [ADDR_W-1:0] IMG_STEP   = ADDR_W'(IMG_LEN);
  localparam logic [ADDR_W-1:0] IMG_BASE_A = ADDR_W'(IMG_BASE);
  localparam logic [ADDR_W-1:0] SV_BASE_A  = ADDR_W'(SV_BASE);
  localparam logic [ADDR_W-1:0] LT_BASE_A  = ADDR_W'(LT_BASE);
  localparam logic [ADDR_W-1:0] B_BASE_A   = ADDR_W'(B_BASE);
  localparam logic [3:0]        LAST_CORE  = 4'(NUM_CORES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_REQ, S_BURST, S_FINISH} state_t;
  typedef enum logic [1:0] {K_IMAGE, K_SV, K_LT, K_BIAS} kind_t;

  state_t            r_state;
  state_t            w_state_nxt;
  kind_t             r_kind;
  logic              r_irq;
  logic [3:0]        r_core;
  logic [9:0]        r_sv_in_core;
  logic [ADDR_W-1:0] r_sv_addr;
  logic [ADDR_W-1:0] r_lt_addr;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_issue_left;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [WIDTH-1:0]  r_fifo [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;
  logic              r_pend;
  logic              r_err;

  logic [9:0]        w_counts [16];
  logic [9:0]        w_cur_cnt;
  logic [9:0]        w_next_cnt;
  logic              w_irq_edge;
  logic              w_pop;
  logic              w_issue;
  logic              w_last_word;
  logic              w_last_core;
  logic [2:0]        w_occ;
  logic [CNT_W-1:0]  w_burst_len;
  logic [ADDR_W-1:0] w_start_addr;

  // Unused table slots read as zero so core_idx can index without range checks.
  generate
    for (genvar i = 0; i < 16; i++) begin : g_counts
      if (i < NUM_CORES) begin : g_used
        assign w_counts[i] = SV_COUNTS[i*10 +: 10];
      end else begin : g_unused
        assign w_counts[i] = 10'd0;
      end
    end
  endgenerate

  assign w_cur_cnt   = w_counts[r_core];
  assign w_next_cnt  = w_counts[r_core + 4'd1];
  assign w_last_core = (r_core == LAST_CORE);
  assign w_irq_edge  = interrupt & ~r_irq;

  assign svalid   = (r_count != 2'd0);
  assign sdata    = r_fifo[r_rd_ptr];
  assign mem_addr = r_ptr;
  assign core_idx = r_core;
  assign err      = r_err;

  assign w_pop       = svalid & sready;
  assign w_burst_len = (r_kind == K_IMAGE || r_kind == K_SV) ? IMG_LEN_C : CNT_W'(1);
  assign w_last_word = (r_state == S_BURST) && w_pop && (r_word_cnt == w_burst_len - CNT_W'(1));

  // Counting the slot freed by this cycle's pop keeps the stream bubble-free.
  assign w_occ   = 3'(r_count) + 3'(r_pend) - 3'(w_pop);
  assign w_issue = (r_state == S_BURST) && (r_issue_left != '0) && (w_occ < 3'd2);

  always_comb begin
    w_start_addr = IMG_BASE_A;
    case (r_kind)
      K_IMAGE: w_start_addr = IMG_BASE_A;
      K_SV:    w_start_addr = r_sv_addr;
      K_LT:    w_start_addr = r_lt_addr;
      K_BIAS:  w_start_addr = B_BASE_A + ADDR_W'(r_core);
      default: w_start_addr = IMG_BASE_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_en      = w_issue;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_WAIT_REQ;
      end
      S_WAIT_REQ: begin
        busy = 1'b1;
        if (w_irq_edge) w_state_nxt = S_BURST;
      end
      S_BURST: begin
        busy = 1'b1;
        if (w_last_word)
          w_state_nxt = (r_kind == K_BIAS && w_last_core) ? S_FINISH : S_WAIT_REQ;
      end
      S_FINISH: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq        <= 1'b0;
      r_err        <= 1'b0;
      r_kind       <= K_IMAGE;
      r_core       <= 4'd0;
      r_sv_in_core <= 10'd0;
      r_sv_addr    <= '0;
      r_lt_addr    <= '0;
      r_ptr        <= '0;
      r_issue_left <= '0;
      r_word_cnt   <= '0;
      r_fifo[0]    <= '0;
      r_fifo[1]    <= '0;
      r_rd_ptr     <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_count      <= 2'd0;
      r_pend       <= 1'b0;
    end else begin
      r_irq <= interrupt;

      if (r_state == S_IDLE && start)
        r_err <= 1'b0;
      else if ((r_state == S_BURST || r_state == S_FINISH) && w_irq_edge)
        r_err <= 1'b1;

      if (r_state == S_IDLE && start) begin
        r_kind       <= K_IMAGE;
        r_core       <= 4'd0;
        r_sv_in_core <= 10'd0;
        r_sv_addr    <= SV_BASE_A;
        r_lt_addr    <= LT_BASE_A;
      end

      if (r_state == S_WAIT_REQ && w_irq_edge) begin
        r_ptr        <= w_start_addr;
        r_issue_left <= w_burst_len;
        r_word_cnt   <= '0;
      end else if (w_issue) begin
        r_ptr        <= r_ptr + ADDR_W'(1);
        r_issue_left <= r_issue_left - CNT_W'(1);
      end

      if (w_pop && r_state == S_BURST)
        r_word_cnt <= r_word_cnt + CNT_W'(1);

      // Step the burst sequence once the current burst has fully drained.
      if (w_last_word) begin
        case (r_kind)
          K_IMAGE: r_kind <= (w_cur_cnt == 10'd0) ? K_BIAS : K_SV;
          K_SV: begin
            r_sv_addr <= r_sv_addr + IMG_STEP;
            r_kind    <= K_LT;
          end
          K_LT: begin
            r_lt_addr <= r_lt_addr + ADDR_W'(1);
            if (r_sv_in_core + 10'd1 == w_cur_cnt) begin
              r_sv_in_core <= 10'd0;
              r_kind       <= K_BIAS;
            end else begin
              r_sv_in_core <= r_sv_in_core + 10'd1;
              r_kind       <= K_SV;
            end
          end
          K_BIAS: begin
            if (!w_last_core) begin
              r_core <= r_core + 4'd1;
              r_kind <= (w_next_cnt == 10'd0) ? K_BIAS : K_SV;
            end
          end
          default: r_kind <= K_IMAGE;
        endcase
      end

      r_pend <= w_issue;
      if (r_pend) begin
        r_fifo[r_wr_ptr] <= mem_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(r_pend) - 2'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_svm_stream_feeder.sv
//============================================================================
// tb_svm_stream_feeder
//   Directed bench: one full-size feeder plus two small configurations.
//   Revision: 1.0
//============================================================================
`default_nettype none

module tb_svm_stream_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   sel;
  logic start_d, int_d, sready_d;
  int   n_vec = 0;
  int   n_bad = 0;

  logic [15:0] got_q [$];
  logic [3:0]  core_q [$];

  // Instance a: default parameters; b: full small sequence; z: zero-SV core 0
  logic        start_a, int_a, sready_a, svalid_a, mem_en_a, busy_a, done_a, err_a;
  logic [15:0] sdata_a, mem_data_a;
  logic [21:0] mem_addr_a;
  logic [3:0]  core_a;
  logic        start_b, int_b, sready_b, svalid_b, mem_en_b, busy_b, done_b, err_b;
  logic [15:0] sdata_b, mem_data_b;
  logic [21:0] mem_addr_b;
  logic [3:0]  core_b;
  logic        start_z, int_z, sready_z, svalid_z, mem_en_z, busy_z, done_z, err_z;
  logic [15:0] sdata_z, mem_data_z;
  logic [21:0] mem_addr_z;
  logic [3:0]  core_z;

  assign start_a  = (sel == 0) ? start_d  : 1'b0;
  assign int_a    = (sel == 0) ? int_d    : 1'b0;
  assign sready_a = (sel == 0) ? sready_d : 1'b0;
  assign start_b  = (sel == 1) ? start_d  : 1'b0;
  assign int_b    = (sel == 1) ? int_d    : 1'b0;
  assign sready_b = (sel == 1) ? sready_d : 1'b0;
  assign start_z  = (sel == 2) ? start_d  : 1'b0;
  assign int_z    = (sel == 2) ? int_d    : 1'b0;
  assign sready_z = (sel == 2) ? sready_d : 1'b0;

  always @(posedge clk) if (mem_en_a) mem_data_a <= mem_addr_a[15:0];
  always @(posedge clk) if (mem_en_b) mem_data_b <= mem_addr_b[15:0];
  always @(posedge clk) if (mem_en_z) mem_data_z <= mem_addr_z[15:0];

  svm_stream_feeder dut_a (
    .clk(clk), .reset(reset), .start(start_a), .interrupt(int_a),
    .sdata(sdata_a), .svalid(svalid_a), .sready(sready_a),
    .mem_addr(mem_addr_a), .mem_en(mem_en_a), .mem_data(mem_data_a),
    .busy(busy_a), .core_idx(core_a), .done(done_a), .err(err_a));

  svm_stream_feeder #(.IMG_LEN(4), .NUM_CORES(2), .SV_COUNTS({10'd1, 10'd2}),
                      .SV_BASE(4), .LT_BASE(100), .B_BASE(200)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .interrupt(int_b),
    .sdata(sdata_b), .svalid(svalid_b), .sready(sready_b),
    .mem_addr(mem_addr_b), .mem_en(mem_en_b), .mem_data(mem_data_b),
    .busy(busy_b), .core_idx(core_b), .done(done_b), .err(err_b));

  svm_stream_feeder #(.IMG_LEN(4), .NUM_CORES(2), .SV_COUNTS({10'd1, 10'd0}),
                      .SV_BASE(4), .LT_BASE(100), .B_BASE(200)) dut_z (
    .clk(clk), .reset(reset), .start(start_z), .interrupt(int_z),
    .sdata(sdata_z), .svalid(svalid_z), .sready(sready_z),
    .mem_addr(mem_addr_z), .mem_en(mem_en_z), .mem_data(mem_data_z),
    .busy(busy_z), .core_idx(core_z), .done(done_z), .err(err_z));

  logic [15:0] obs_sdata;
  logic [21:0] obs_addr;
  logic [3:0]  obs_core;
  logic        obs_svalid, obs_mem_en, obs_busy, obs_done, obs_err;

  always_comb begin
    obs_sdata = sdata_a; obs_addr = mem_addr_a; obs_core = core_a; obs_svalid = svalid_a;
    obs_mem_en = mem_en_a; obs_busy = busy_a; obs_done = done_a; obs_err = err_a;
    if (sel == 1) begin
      obs_sdata = sdata_b; obs_addr = mem_addr_b; obs_core = core_b; obs_svalid = svalid_b;
      obs_mem_en = mem_en_b; obs_busy = busy_b; obs_done = done_b; obs_err = err_b;
    end else if (sel == 2) begin
      obs_sdata = sdata_z; obs_addr = mem_addr_z; obs_core = core_z; obs_svalid = svalid_z;
      obs_mem_en = mem_en_z; obs_busy = busy_z; obs_done = done_z; obs_err = err_z;
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; start_d = 1'b0; int_d = 1'b0; sready_d = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start_d = 1'b1;
    @(posedge clk); #1; start_d = 1'b0;
  endtask

  // Raises interrupt for one cycle and collects one burst with sready held high.
  task automatic run_burst(input int max_cyc, input int inj_cyc, output int first_en,
                           output int first_val, output int last_val, output int max_fly,
                           output int done_seen, output bit timed_out);
    int cyc, issued, accepted;
    bit fin;
    got_q.delete(); core_q.delete();
    first_en = -1; first_val = -1; last_val = -1; max_fly = 0; done_seen = 0;
    cyc = 0; issued = 0; accepted = 0; fin = 1'b0;
    sready_d = 1'b1; int_d = 1'b1;
    while (!fin && cyc < max_cyc) begin
      @(posedge clk); #1; cyc++;
      int_d = (inj_cyc != 0 && cyc == inj_cyc);
      #1;
      if (obs_mem_en) begin issued++; if (first_en < 0) first_en = cyc; end
      if (obs_done) done_seen++;
      if (obs_svalid) begin
        if (first_val < 0) first_val = cyc;
        last_val = cyc;
        got_q.push_back(obs_sdata); core_q.push_back(obs_core);
        accepted++;
      end else if (first_val >= 0) fin = 1'b1;
      if (issued - accepted > max_fly) max_fly = issued - accepted;
    end
    timed_out = !fin;
  endtask

  task automatic test_reset();
    logic [50:0] zero = '0;
    int en_cnt;
    sel = 0;
    #12;
    n_vec++;
    if ({obs_sdata, obs_svalid, obs_mem_en, obs_addr, obs_busy, obs_done, obs_core, obs_err} !== zero) begin
      n_bad++; $display("FAIL reset_values: got %h want 0",
        {obs_sdata, obs_svalid, obs_mem_en, obs_addr, obs_busy, obs_done, obs_core, obs_err});
    end
    reset = 1'b0;
    pulse_start();
    sready_d = 1'b1; int_d = 1'b1;
    @(posedge clk); #1; int_d = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    n_vec++;
    if (obs_svalid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_stream: svalid %b want 1", obs_svalid); end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({obs_sdata, obs_svalid, obs_mem_en, obs_addr, obs_busy, obs_done, obs_core, obs_err} !== zero) begin
      n_bad++; $display("FAIL async_reset: got %h want 0",
        {obs_sdata, obs_svalid, obs_mem_en, obs_addr, obs_busy, obs_done, obs_core, obs_err});
    end
    #3; reset = 1'b0;
    en_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      int_d = (c == 2);
      #1;
      if (obs_mem_en || obs_svalid) en_cnt++;
    end
    n_vec++;
    if (en_cnt !== 0) begin n_bad++; $display("FAIL reset_no_reads: active cycles %0d want 0", en_cnt); end
    n_vec++;
    if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: busy %b want 0", obs_busy); end
  endtask

  task automatic test_image();
    int fe, fv, lv, mf, ds, bad;
    bit to;
    sel = 0;
    do_reset();
    pulse_start();
    n_vec++;
    if (obs_busy !== 1'b1) begin n_bad++; $display("FAIL image_busy_rise: busy %b want 1", obs_busy); end
    run_burst(2000, 0, fe, fv, lv, mf, ds, to);
    bad = 0;
    foreach (got_q[i]) if (got_q[i] !== 16'(i)) bad++;
    n_vec++;
    if (to !== 1'b0 || got_q.size() !== 784) begin
      n_bad++; $display("FAIL image_count: got %0d words timeout %b want 784", got_q.size(), to);
    end
    n_vec++;
    if (bad !== 0) begin n_bad++; $display("FAIL image_data: wrong words %0d want 0", bad); end
    n_vec++;
    if (fe !== 1) begin n_bad++; $display("FAIL image_first_mem_en: cycle %0d want 1", fe); end
    n_vec++;
    if (fv !== 3) begin n_bad++; $display("FAIL image_first_valid: cycle %0d want 3", fv); end
    n_vec++;
    if (lv - fv + 1 !== 784) begin n_bad++; $display("FAIL image_valid_span: %0d cycles want 784", lv - fv + 1); end
    n_vec++;
    if (mf > 2) begin n_bad++; $display("FAIL image_in_flight: max %0d want <=2", mf); end
    n_vec++;
    if (obs_busy !== 1'b1 || obs_err !== 1'b0) begin
      n_bad++; $display("FAIL image_status: busy %b err %b want busy 1 err 0", obs_busy, obs_err);
    end
  endtask

  task automatic test_backpressure();
    int cyc, xfers, stall, bad_hold, bad_data, issued, mf;
    bit fin;
    logic tog;
    sel = 0;
    do_reset();
    pulse_start();
    cyc = 0; xfers = 0; stall = 0; bad_hold = 0; bad_data = 0; issued = 0; mf = 0;
    fin = 1'b0; tog = 1'b0;
    int_d = 1'b1;
    while (!fin && cyc < 4000) begin
      @(posedge clk); #1; cyc++;
      int_d = 1'b0;
      if (xfers < 100) sready_d = 1'b1;
      else if (stall < 5) begin
        sready_d = 1'b0; stall++;
        if (!(obs_svalid === 1'b1 && obs_sdata === 16'd100)) bad_hold++;
      end else begin
        sready_d = tog; tog = ~tog;
      end
      #1;
      if (obs_mem_en) issued++;
      if (obs_svalid && sready_d) begin
        if (obs_sdata !== 16'(xfers)) bad_data++;
        xfers++;
      end
      if (issued - xfers > mf) mf = issued - xfers;
      if (xfers == 784 && !obs_svalid) fin = 1'b1;
    end
    n_vec++;
    if (fin !== 1'b1 || xfers !== 784) begin
      n_bad++; $display("FAIL bp_count: transfers %0d done %b want 784", xfers, fin);
    end
    n_vec++;
    if (bad_data !== 0) begin n_bad++; $display("FAIL bp_data: wrong words %0d want 0", bad_data); end
    n_vec++;
    if (stall !== 5 || bad_hold !== 0) begin
      n_bad++; $display("FAIL bp_hold: stall %0d bad %0d want 5 and 0", stall, bad_hold);
    end
    n_vec++;
    if (issued !== 784) begin n_bad++; $display("FAIL bp_reads: issued %0d want 784", issued); end
    n_vec++;
    if (mf > 2) begin n_bad++; $display("FAIL bp_in_flight: max %0d want <=2", mf); end
  endtask

  task automatic test_illegal();
    int fe, fv, lv, mf, ds, bad, act;
    bit to;
    sel = 0;
    do_reset();
    act = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      int_d = (c == 1);
      #1;
      if (obs_mem_en || obs_svalid || obs_busy) act++;
    end
    n_vec++;
    if (act !== 0) begin n_bad++; $display("FAIL idle_irq_activity: %0d cycles want 0", act); end
    n_vec++;
    if (obs_err !== 1'b0) begin n_bad++; $display("FAIL idle_irq_err: err %b want 0", obs_err); end
    pulse_start();
    run_burst(2000, 50, fe, fv, lv, mf, ds, to);
    bad = 0;
    foreach (got_q[i]) if (got_q[i] !== 16'(i)) bad++;
    n_vec++;
    if (to !== 1'b0 || got_q.size() !== 784 || bad !== 0) begin
      n_bad++; $display("FAIL illegal_burst: words %0d bad %0d timeout %b want 784 0 0", got_q.size(), bad, to);
    end
    n_vec++;
    if (obs_err !== 1'b1) begin n_bad++; $display("FAIL illegal_err_set: err %b want 1", obs_err); end
  endtask

  task automatic test_full_sequence();
    int st [9] = '{0, 4, 100, 8, 101, 200, 12, 102, 201};
    int ln [9] = '{4, 4, 1, 4, 1, 1, 4, 1, 1};
    int cr [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    int fe, fv, lv, mf, ds, bad, done_tot;
    bit to;
    sel = 1;
    do_reset();
    pulse_start();
    done_tot = 0;
    for (int b = 0; b < 9; b++) begin
      run_burst(50, (b == 1) ? 3 : 0, fe, fv, lv, mf, ds, to);
      done_tot += ds;
      bad = (got_q.size() != ln[b]) ? 1 : 0;
      foreach (got_q[i]) if (got_q[i] !== 16'(st[b] + i) || core_q[i] !== 4'(cr[b])) bad++;
      n_vec++;
      if (bad !== 0 || to !== 1'b0) begin
        n_bad++; $display("FAIL seq_burst%0d: words %0d first %h core %0d want %0d words from %0d core %0d",
          b, got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx,
          (core_q.size() > 0) ? core_q[0] : 4'hx, ln[b], st[b], cr[b]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      if (obs_done) done_tot++;
    end
    n_vec++;
    if (done_tot !== 1) begin n_bad++; $display("FAIL seq_done: pulses %0d want 1", done_tot); end
    n_vec++;
    if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL seq_busy_fall: busy %b want 0", obs_busy); end
    n_vec++;
    if (obs_err !== 1'b1) begin n_bad++; $display("FAIL seq_err_sticky: err %b want 1", obs_err); end
    pulse_start();
    n_vec++;
    if (obs_err !== 1'b0 || obs_busy !== 1'b1) begin
      n_bad++; $display("FAIL start_clears_err: err %b busy %b want 0 1", obs_err, obs_busy);
    end
  endtask

  task automatic test_zero_sv();
    int st [5] = '{0, 200, 4, 100, 201};
    int ln [5] = '{4, 1, 4, 1, 1};
    int cr [5] = '{0, 0, 1, 1, 1};
    int fe, fv, lv, mf, ds, bad, done_tot;
    bit to;
    sel = 2;
    do_reset();
    pulse_start();
    done_tot = 0;
    for (int b = 0; b < 5; b++) begin
      run_burst(50, 0, fe, fv, lv, mf, ds, to);
      done_tot += ds;
      bad = (got_q.size() != ln[b]) ? 1 : 0;
      foreach (got_q[i]) if (got_q[i] !== 16'(st[b] + i) || core_q[i] !== 4'(cr[b])) bad++;
      n_vec++;
      if (bad !== 0 || to !== 1'b0) begin
        n_bad++; $display("FAIL zsv_burst%0d: words %0d first %h want %0d words from %0d core %0d",
          b, got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx, ln[b], st[b], cr[b]);
      end
    end
    n_vec++;
    if (done_tot !== 1 || obs_busy !== 1'b0) begin
      n_bad++; $display("FAIL zsv_end: done pulses %0d busy %b want 1 0", done_tot, obs_busy);
    end
  endtask

  initial begin
    reset = 1'b1; sel = 0; start_d = 1'b0; int_d = 1'b0; sready_d = 1'b0;
    test_reset();
    test_image();
    test_backpressure();
    test_illegal();
    test_full_sequence();
    test_zero_sv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
